// File: rtl/mfp8_to_flopoco_pair.sv
`default_nettype none
// ============================================================================
// Module      : mfp8_to_flopoco_pair
// Description : E4M3 minifloat pair to FloPoCo (wE=4, wF=3) operand converter
//               with a one-stage valid/ready output register and status.
// Revision    : 1.0 - initial release
// ============================================================================
module mfp8_to_flopoco_pair #(
    parameter int ID    = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       X,
    output logic [9:0]       Y,
    input  logic             stat_clr,
    output logic             nan_seen,
    output logic [CNT_W-1:0] uflow_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             r_valid;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_nan;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_nan_a;
    logic             w_nan_b;
    logic             w_flush_a;
    logic             w_flush_b;
    logic [1:0]       w_flush_n;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // Exponent bias matches between formats, so normals pass straight through.
    function automatic logic [9:0] f_conv(input logic [7:0] v);
        logic [9:0] r;
        r = {2'b00, v[7], 7'd0};
        if (v[6:3] == 4'hF)
            r[9:8] = (v[2:0] == 3'd0) ? 2'b10 : 2'b11;
        else if (v[6:3] != 4'h0)
            r = {2'b01, v};
        else if (v[2])
            r = {2'b01, v[7], 4'd0, v[1:0], 1'b0};
        return r;
    endfunction

    // Instance tag carries no logic.
    if (ID < 0) begin : g_id_tag
    end

    assign in_ready  = ~r_valid | out_ready;
    assign w_accept  = in_valid & in_ready;

    assign w_nan_a   = (&in_a[6:3]) & (|in_a[2:0]);
    assign w_nan_b   = (&in_b[6:3]) & (|in_b[2:0]);
    assign w_flush_a = ~(|in_a[6:3]) & ~in_a[2] & (|in_a[1:0]);
    assign w_flush_b = ~(|in_b[6:3]) & ~in_b[2] & (|in_b[1:0]);
    assign w_flush_n = {1'b0, w_flush_a} + {1'b0, w_flush_b};

    // One extra sum bit catches overflow so the counter saturates, never wraps.
    assign w_cnt_sum  = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, w_flush_n};
    assign w_cnt_next = w_cnt_sum[CNT_W] ? c_cnt_max : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_x     <= f_conv(in_a);
            r_y     <= f_conv(in_b);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            r_nan <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_nan <= r_nan | w_nan_a | w_nan_b;
            r_cnt <= w_cnt_next;
        end
    end

    assign out_valid = r_valid;
    assign X         = r_x;
    assign Y         = r_y;
    assign nan_seen  = r_nan;
    assign uflow_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mfp8_to_flopoco_pair.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfp8_to_flopoco_pair
// Description : Scoreboard bench for mfp8_to_flopoco_pair with a value-class
//               reference model, directed boundary cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp8_to_flopoco_pair;

    localparam int c_cnt_w   = 8;
    localparam int c_cnt_max = (1 << c_cnt_w) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_a;
    logic [7:0]         in_b;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         X;
    logic [9:0]         Y;
    logic               stat_clr;
    logic               nan_seen;
    logic [c_cnt_w-1:0] uflow_cnt;

    mfp8_to_flopoco_pair #(.ID(1), .CNT_W(c_cnt_w)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
        .Y         (Y),
        .stat_clr  (stat_clr),
        .nan_seen  (nan_seen),
        .uflow_cnt (uflow_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] sb_q[$];
    logic        m_nan     = 1'b0;
    int          m_cnt     = 0;
    logic        m_zero    = 1'b0;
    logic        m_started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode the minifloat into its value class, then build the operand.
    function automatic logic [9:0] ref_conv(input logic [7:0] v);
        int  e    = int'(v[6:3]);
        int  f    = int'(v[2:0]);
        logic s   = v[7];
        if (e == 15 && f == 0) return {2'b10, s, 7'd0};
        if (e == 15)           return {2'b11, s, 7'd0};
        if (e >= 1)            return {2'b01, s, 4'(e), 3'(f)};
        if (f >= 4)            return {2'b01, s, 4'd0, 3'((f - 4) * 2)};
        return {2'b00, s, 7'd0};
    endfunction

    function automatic bit is_nan(input logic [7:0] v);
        return (v[6:3] == 4'hF) && (v[2:0] != 3'd0);
    endfunction

    function automatic int n_flush(input logic [7:0] v);
        return (v[6:3] == 4'h0 && v[2:0] != 3'd0 && v[2:0] < 3'd4) ? 1 : 0;
    endfunction

    // Model: inputs settle 1 time unit after each rising edge, so they are stable here.
    always @(posedge clk) begin
        bit acc;
        m_started = 1'b1;
        if (!rst_n) begin
            sb_q.delete();
            m_nan  = 1'b0;
            m_cnt  = 0;
            m_zero = 1'b1;
        end else begin
            acc = in_valid && (sb_q.size() == 0 || out_ready);
            if (acc) begin
                sb_q.push_back({ref_conv(in_a), ref_conv(in_b)});
                m_zero = 1'b0;
            end
            if (stat_clr) begin
                m_nan = 1'b0;
                m_cnt = 0;
            end else if (acc) begin
                m_nan = m_nan | is_nan(in_a) | is_nan(in_b);
                m_cnt = m_cnt + n_flush(in_a) + n_flush(in_b);
                if (m_cnt > c_cnt_max) m_cnt = c_cnt_max;
            end
        end
    end

    // Monitor: sample mid-cycle; a transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || out_ready));
            if (sb_q.size() != 0) begin
                check("XY", {12'd0, X, Y}, {12'd0, sb_q[0]});
                if (out_ready) void'(sb_q.pop_front());
            end else if (m_zero) begin
                check("XY_reset", {12'd0, X, Y}, 32'd0);
            end
            check("nan_seen", 32'(nan_seen), 32'(m_nan));
            check("uflow_cnt", 32'(uflow_cnt), 32'(m_cnt));
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, input logic clr);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        stat_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_op();
        logic [7:0] v;
        logic s = 1'($urandom);
        case ($urandom_range(0, 5))
            0: v = {s, 4'hF, 3'd0};
            1: v = {s, 4'hF, 3'($urandom_range(1, 7))};
            2: v = {s, 4'($urandom_range(1, 14)), 3'($urandom)};
            3: v = {s, 7'd0};
            4: v = {s, 4'h0, 3'($urandom_range(4, 7))};
            default: v = {s, 4'h0, 3'($urandom_range(1, 3))};
        endcase
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h55, 8'hAA, 1'b1, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Normals and back-to-back streaming
        drive(1'b1, 8'h38, 8'hB8, 1'b1, 1'b0);
        drive(1'b1, 8'h41, 8'h77, 1'b1, 1'b0);
        drive(1'b1, 8'h08, 8'hF7, 1'b1, 1'b0);
        // Specials and signed zero
        drive(1'b1, 8'h78, 8'hFF, 1'b1, 1'b0);
        drive(1'b1, 8'h80, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'hF8, 8'h79, 1'b1, 1'b0);
        // Subnormals: representable, then flushed pair
        drive(1'b1, 8'h06, 8'h87, 1'b1, 1'b0);
        drive(1'b1, 8'h02, 8'h81, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Backpressure: one accept, five stalled cycles with ignored offers
        drive(1'b1, 8'h3A, 8'hC5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 8'h05, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Saturation: 254 events then +2, then 254 then +1 and +2
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 127; i++) drive(1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        drive(1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 127; i++) drive(1'b1, 8'h03, 8'h82, 1'b1, 1'b0);
        drive(1'b1, 8'h01, 8'h38, 1'b1, 1'b0);
        drive(1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        // Clear wins over a same-cycle NaN/flush accept
        drive(1'b1, 8'h7F, 8'h01, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Reset during a stall discards the held pair and status
        drive(1'b1, 8'hFA, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Random traffic with random backpressure and occasional clears
        for (int i = 0; i < 600; i++)
            drive(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
